prog_mem: RTL and testbench

PROG_MEM -- requirements
Module: prog_mem

---
 rtl/prog_pkg.sv | 69 ++++++
 rtl/prog_boot_seq.sv | 45 ++++
 rtl/prog_mem.sv | 133 +++++++++++++
 tb/tb_prog_mem.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// Shared opcode/operand constants, boot image and state type for prog_mem.
// Imported by prog_boot_seq and prog_mem.
package prog_pkg;

    localparam int BOOT_LEN_DEF = 41;

    // Immediate and move opcodes
    localparam logic [7:0] IMM1 = 8'hC0;
    localparam logic [7:0] IMM2 = 8'hC1;
    localparam logic [7:0] MOV  = 8'h11;

    // ALU opcodes
    localparam logic [7:0] ALU_ADD = 8'h20;
    localparam logic [7:0] ALU_SUB = 8'h21;
    localparam logic [7:0] ALU_AND = 8'h22;
    localparam logic [7:0] ALU_OR  = 8'h23;
    localparam logic [7:0] ALU_XOR = 8'h24;

    // Operand codes
    localparam logic [7:0] REG_A   = 8'h00;
    localparam logic [7:0] REG_B   = 8'h01;
    localparam logic [7:0] RAM     = 8'h04;
    localparam logic [7:0] STACK   = 8'h05;
    localparam logic [7:0] COUNTER = 8'h06;
    localparam logic [7:0] IO      = 8'h07;

    // Branch conditions
    localparam logic [7:0] COND_ALWAYS = 8'h00;
    localparam logic [7:0] COND_Z      = 8'h01;
    localparam logic [7:0] COND_NZ     = 8'h02;
    localparam logic [7:0] COND_C      = 8'h03;

    // Control flow
    localparam logic [7:0] CALL = 8'h30;
    localparam logic [7:0] RET  = 8'h31;
    localparam logic [7:0] HALT = 8'h32;

    localparam logic [7:0] BOOT_IMAGE [BOOT_LEN_DEF] = '{
        IMM1,    REG_A,   8'h00,   MOV,
        REG_A,   COUNTER, IMM2,    REG_B,
        8'h01,   8'h00,   ALU_ADD, REG_A,
        REG_B,   MOV,     REG_A,   IO,
        CALL,    COND_ALWAYS, 8'h20, ALU_SUB,
        COUNTER, REG_B,   CALL,    COND_NZ,
        8'h0A,   HALT,    8'h00,   8'h00,
        8'h00,   8'h00,   8'h00,   8'h00,
        MOV,     REG_A,   STACK,   ALU_XOR,
        REG_A,   RAM,     RET,     8'h00,
        HALT
    };

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_LOAD
    } state_e;

    // Bytes past the stored image read as zero, so a longer BOOT_LEN
    // simply extends the image with zeros.
    function automatic logic [7:0] boot_byte(input int i);
        logic [5:0] idx;
        idx = i[5:0];
        if (i >= 0 && i < BOOT_LEN_DEF)
            boot_byte = BOOT_IMAGE[idx];
        else
            boot_byte = 8'h00;
    endfunction

endpackage

// File: rtl/prog_boot_seq.sv
// Boot copy sequencer: steps a byte index from 0 to BOOT_LEN-1 once per
// clock after reset, strobing we_o; done_o marks the last byte's cycle.
// Ports: clk, rst (async, active-high), idx_o, we_o, done_o.
module prog_boot_seq #(
    parameter int IDX_W    = 8,
    parameter int BOOT_LEN = 41
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx_o,
    output logic             we_o,
    output logic             done_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(BOOT_LEN - 1);

    logic             active_q, active_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b1;
            idx_q    <= '0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        if (active_q) begin
            if (idx_q == LAST)
                active_d = 1'b0;
            else
                idx_d = idx_q + 1'b1;
        end
    end

    assign idx_o  = idx_q;
    assign we_o   = active_q;
    assign done_o = active_q && (idx_q == LAST);

endmodule

// File: rtl/prog_mem.sv
// Byte-addressed program memory: boot-image copy after reset, line loads
// in LOAD mode, unaligned wrapping instruction fetch in RUN mode.
// Ports: clk, rst, edit, ld_valid/ld_ready/ld_line/ld_code/ld_err,
//        fetch_en/fetch_addr, opcode/opcode_valid, busy.
// Optional macro PROG_MEM_WP_EN: reject loads touching the boot region.
module prog_mem
    import prog_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int INSTR_BYTES = 4,
    parameter int BOOT_LEN    = BOOT_LEN_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               edit,
    input  logic                               ld_valid,
    output logic                               ld_ready,
    input  logic [ADDR_W-$clog2(INSTR_BYTES)-1:0] ld_line,
    input  logic [8*INSTR_BYTES-1:0]           ld_code,
    output logic                               ld_err,
    input  logic                               fetch_en,
    input  logic [ADDR_W-1:0]                  fetch_addr,
    output logic [8*INSTR_BYTES-1:0]           opcode,
    output logic                               opcode_valid,
    output logic                               busy
);

    localparam int N     = INSTR_BYTES;
    localparam int OB    = $clog2(INSTR_BYTES);
    localparam int DEPTH = 2 ** ADDR_W;

    state_e state_q, state_d;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] boot_idx;
    logic              boot_we;
    logic              boot_done;

    logic [ADDR_W-1:0] ld_base;
    logic              ld_acc;
    logic              wp_hit;
    logic              ld_we;
    logic              ld_err_q;

    logic              fetch_go;
    logic [8*N-1:0]    rd_word;
    logic [8*N-1:0]    opcode_q;
    logic              opcode_valid_q;

    prog_boot_seq #(
        .IDX_W   (ADDR_W),
        .BOOT_LEN(BOOT_LEN)
    ) u_boot (
        .clk   (clk),
        .rst   (rst),
        .idx_o (boot_idx),
        .we_o  (boot_we),
        .done_o(boot_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_BOOT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: if (boot_done) state_d = ST_RUN;
            ST_RUN:  if (edit)      state_d = ST_LOAD;
            ST_LOAD: if (!edit)     state_d = ST_RUN;
            default:                state_d = ST_BOOT;
        endcase
    end

    assign busy     = (state_q == ST_BOOT);
    assign ld_ready = (state_q == ST_LOAD);

    assign ld_base = ADDR_W'(ld_line) << OB;
    assign ld_acc  = ld_valid && ld_ready;

`ifdef PROG_MEM_WP_EN
    // Line bytes start at ld_base, so any overlap with the boot region
    // means the line start itself lies below BOOT_LEN.
    assign wp_hit = (int'(ld_base) < BOOT_LEN);
`else
    assign wp_hit = 1'b0;
`endif

    assign ld_we = ld_acc && !wp_hit;

    // Reset clears the whole array so bytes past the boot image read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 8'h00;
        end else if (boot_we) begin
            mem_q[boot_idx] <= boot_byte(int'(boot_idx));
        end else if (ld_we) begin
            for (int k = 0; k < N; k++)
                mem_q[ld_base + ADDR_W'(k)] <= ld_code[8*k +: 8];
        end
    end

    // Byte-wise gather: addresses wrap naturally in ADDR_W bits.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < N; k++)
            rd_word[8*k +: 8] = mem_q[fetch_addr + ADDR_W'(k)];
    end

    assign fetch_go = fetch_en && (state_q == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q       <= '0;
            opcode_valid_q <= 1'b0;
            ld_err_q       <= 1'b0;
        end else begin
            opcode_valid_q <= fetch_go;
            ld_err_q       <= ld_acc && wp_hit;
            if (fetch_go)
                opcode_q <= rd_word;
        end
    end

    assign opcode       = opcode_q;
    assign opcode_valid = opcode_valid_q;
    assign ld_err       = ld_err_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed testbench for prog_mem: boot, fetch, load, wrap, protection
// and reset-abort scenarios with hand-computed expected words.
module tb_prog_mem;

    logic        clk;
    logic        rst;
    logic        edit;
    logic        ld_valid;
    logic        ld_ready;
    logic [5:0]  ld_line;
    logic [31:0] ld_code;
    logic        ld_err;
    logic        fetch_en;
    logic [7:0]  fetch_addr;
    logic [31:0] opcode;
    logic        opcode_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    prog_mem dut (
        .clk         (clk),
        .rst         (rst),
        .edit        (edit),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_line     (ld_line),
        .ld_code     (ld_code),
        .ld_err      (ld_err),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .opcode      (opcode),
        .opcode_valid(opcode_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] a);
        fetch_en   = 1'b1;
        fetch_addr = a;
        step();
        fetch_en   = 1'b0;
    endtask

    // Counts busy cycles with a fetch of address 0 held pending; the
    // fetch must only be served once BOOT has finished.
    task automatic run_boot(input string tag);
        int   cnt;
        logic saw_valid;
        cnt        = 0;
        saw_valid  = 1'b0;
        fetch_en   = 1'b1;
        fetch_addr = 8'd0;
        while (busy && cnt < 200) begin
            if (opcode_valid) saw_valid = 1'b1;
            cnt++;
            step();
        end
        checks++;
        if (cnt !== 41) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d expected 41", tag, cnt);
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid_in_boot: got %b expected 0", tag, saw_valid);
        end
        step();
        fetch_en = 1'b0;
        checks++;
        if (opcode_valid !== 1'b1 || opcode !== 32'h110000C0) begin
            errors++;
            $display("FAIL %s_fetch0: got v=%b %h expected v=1 110000c0",
                     tag, opcode_valid, opcode);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b1 || ld_ready !== 1'b0 || ld_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b rdy=%b err=%b expected 1 0 0",
                     busy, ld_ready, ld_err);
        end
        checks++;
        if (opcode !== 32'h0 || opcode_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_opcode: got v=%b %h expected v=0 00000000",
                     opcode_valid, opcode);
        end
        rst = 1'b0;
        run_boot("boot");
        step();
        checks++;
        if (opcode_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse: got %b expected 0", opcode_valid);
        end
    endtask

    task automatic test_boot_contents();
        fetch(8'd4);
        checks++;
        if (opcode !== 32'h01C10600) begin
            errors++;
            $display("FAIL fetch4: got %h expected 01c10600", opcode);
        end
        fetch(8'd40);
        checks++;
        if (opcode !== 32'h00000032) begin
            errors++;
            $display("FAIL fetch40: got %h expected 00000032", opcode);
        end
        fetch(8'd44);
        checks++;
        if (opcode !== 32'h00000000) begin
            errors++;
            $display("FAIL fetch44: got %h expected 00000000", opcode);
        end
    endtask

    task automatic test_load_ignored_in_run();
        ld_valid = 1'b1;
        ld_line  = 6'd30;
        ld_code  = 32'h12345678;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_run: got %b expected 0", ld_ready);
        end
        step();
        ld_valid = 1'b0;
        fetch(8'd120);
        checks++;
        if (opcode !== 32'h00000000) begin
            errors++;
            $display("FAIL ignored_load: got %h expected 00000000", opcode);
        end
    endtask

    task automatic test_load_wrap();
        edit = 1'b1;
        step();
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_load: got %b expected 1", ld_ready);
        end
        ld_valid = 1'b1;
        ld_line  = 6'd63;
        ld_code  = 32'hDDCCBBAA;
        edit     = 1'b0;
        step();
        ld_valid = 1'b0;
        fetch(8'd254);
        checks++;
        if (opcode !== 32'h00C0DDCC) begin
            errors++;
            $display("FAIL wrap254: got %h expected 00c0ddcc", opcode);
        end
    endtask

    task automatic test_back_to_back();
        edit = 1'b1;
        step();
        ld_valid = 1'b1;
        ld_line  = 6'd20;
        ld_code  = 32'h11111111;
        step();
        ld_line  = 6'd21;
        ld_code  = 32'h22222222;
        edit     = 1'b0;
        step();
        ld_valid   = 1'b0;
        fetch_en   = 1'b1;
        fetch_addr = 8'd80;
        step();
        checks++;
        if (opcode_valid !== 1'b1 || opcode !== 32'h11111111) begin
            errors++;
            $display("FAIL b2b_80: got v=%b %h expected v=1 11111111",
                     opcode_valid, opcode);
        end
        fetch_addr = 8'd84;
        step();
        checks++;
        if (opcode_valid !== 1'b1 || opcode !== 32'h22222222) begin
            errors++;
            $display("FAIL b2b_84: got v=%b %h expected v=1 22222222",
                     opcode_valid, opcode);
        end
        fetch_addr = 8'd82;
        step();
        checks++;
        if (opcode_valid !== 1'b1 || opcode !== 32'h22221111) begin
            errors++;
            $display("FAIL b2b_82: got v=%b %h expected v=1 22221111",
                     opcode_valid, opcode);
        end
        fetch_en = 1'b0;
        step();
    endtask

    task automatic test_fetch_on_transition();
        edit       = 1'b1;
        fetch_en   = 1'b1;
        fetch_addr = 8'd0;
        step();
        checks++;
        if (opcode_valid !== 1'b1 || opcode !== 32'h110000C0) begin
            errors++;
            $display("FAIL fetch_at_edit: got v=%b %h expected v=1 110000c0",
                     opcode_valid, opcode);
        end
        fetch_addr = 8'd40;
        step();
        fetch_en = 1'b0;
        checks++;
        if (opcode_valid !== 1'b0 || opcode !== 32'h110000C0) begin
            errors++;
            $display("FAIL fetch_in_load: got v=%b %h expected v=0 110000c0",
                     opcode_valid, opcode);
        end
    endtask

    // Entered in LOAD state.
    task automatic test_write_protect();
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef PROG_MEM_WP_EN
        exp_err  = 1'b1;
        exp_word = 32'h00000032;
`else
        exp_err  = 1'b0;
        exp_word = 32'hFFFFFFFF;
`endif
        ld_valid = 1'b1;
        ld_line  = 6'd10;
        ld_code  = 32'hFFFFFFFF;
        edit     = 1'b0;
        step();
        ld_valid = 1'b0;
        checks++;
        if (ld_err !== exp_err) begin
            errors++;
            $display("FAIL wp_err: got %b expected %b", ld_err, exp_err);
        end
        fetch(8'd40);
        checks++;
        if (opcode !== exp_word || ld_err !== 1'b0) begin
            errors++;
            $display("FAIL wp_fetch40: got %h err=%b expected %h err=0",
                     opcode, ld_err, exp_word);
        end
    endtask

    task automatic test_reset_mid_load();
        edit = 1'b1;
        step();
        ld_valid = 1'b1;
        ld_line  = 6'd0;
        ld_code  = 32'hDEADBEEF;
        step();
        ld_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || ld_ready !== 1'b0 || opcode !== 32'h0) begin
            errors++;
            $display("FAIL async_rst: got busy=%b rdy=%b op=%h expected 1 0 0",
                     busy, ld_ready, opcode);
        end
        step();
        step();
        rst = 1'b0;
        run_boot("reboot");
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_after_reboot: got %b expected 1", ld_ready);
        end
        edit = 1'b0;
        step();
    endtask

    initial begin
        rst        = 1'b1;
        edit       = 1'b0;
        ld_valid   = 1'b0;
        ld_line    = '0;
        ld_code    = '0;
        fetch_en   = 1'b0;
        fetch_addr = '0;
        test_reset();
        test_boot_contents();
        test_load_ignored_in_run();
        test_load_wrap();
        test_back_to_back();
        test_fetch_on_transition();
        test_write_protect();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
